tlul_slave_responder: RTL and testbench

TLUL_SLAVE_RESPONDER -- requirements
Module: tlul_slave_responder

---
 rtl/tlul_pkg.sv | 36 +++
 rtl/tlul_slave_responder_if.sv | 51 +++++
 rtl/tlul_slave_mem.sv | 43 ++++
 rtl/tlul_slave_responder.sv | 167 ++++++++++++++++
 tb/tb_tlul_slave_responder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions for the slave responder.
// Holds the A/D channel opcode encodings, the responder FSM state type and a
// small alignment helper used by the request decoder.
package tlul_pkg;

    // A channel opcodes
    typedef enum logic [2:0] {
        PutFullData    = 3'd0,
        PutPartialData = 3'd1,
        Get            = 3'd4
    } tl_a_op_e;

    // D channel opcodes
    typedef enum logic [2:0] {
        AccessAck     = 3'd0,
        AccessAckData = 3'd1
    } tl_d_op_e;

    // Responder FSM
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } tl_state_e;

    // True when the byte address is not aligned to 2^size. Only meaningful for
    // size 0..2; larger sizes are rejected separately.
    function automatic logic tl_misaligned(logic [1:0] addr_lo, logic [1:0] size_lo);
        case (size_lo)
            2'd1:    return addr_lo[0];
            2'd2:    return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tlul_slave_responder_if.sv
// TL-UL A/D channel bundle between a master and the slave responder.
// master modport: drives a_* and d_ready, observes a_ready and d_*.
// slave modport:  drives a_ready and d_*, observes a_* and d_ready.
interface tlul_slave_responder_if #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned SIZE_WIDTH   = 3,
    parameter int unsigned SRC_WIDTH    = 2,
    parameter int unsigned SINK_WIDTH   = 1,
    parameter int unsigned OPCODE_WIDTH = 3,
    parameter int unsigned PARAM_WIDTH  = 3
) ();

    // A channel
    logic                    a_valid;
    logic                    a_ready;
    logic [OPCODE_WIDTH-1:0] a_opcode;
    logic [PARAM_WIDTH-1:0]  a_param;
    logic [SIZE_WIDTH-1:0]   a_size;
    logic [SRC_WIDTH-1:0]    a_source;
    logic [ADDR_WIDTH-1:0]   a_address;
    logic [MASK_WIDTH-1:0]   a_mask;
    logic [DATA_WIDTH-1:0]   a_data;

    // D channel
    logic                    d_valid;
    logic                    d_ready;
    logic [OPCODE_WIDTH-1:0] d_opcode;
    logic [PARAM_WIDTH-1:0]  d_param;
    logic [SIZE_WIDTH-1:0]   d_size;
    logic [SRC_WIDTH-1:0]    d_source;
    logic [SINK_WIDTH-1:0]   d_sink;
    logic [DATA_WIDTH-1:0]   d_data;
    logic                    d_error;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
        input  d_ready
    );

endinterface

// File: rtl/tlul_slave_mem.sv
// Backing store for the TL-UL slave: MEM_DEPTH words of DATA_WIDTH bits with a
// single port offering a synchronous read and a byte-masked write.
// Ports:
//   clk   - clock
//   re    - read enable; rdata updates on the next edge and then holds
//   we    - write enable; bytes with wmask set are written
//   idx   - word index
//   wdata - write data
//   wmask - byte-lane write mask
//   rdata - registered read data
// Contents are not reset.
module tlul_slave_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned IDX_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [MASK_WIDTH-1:0] wmask,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (wmask[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        // rdata only moves on a read so it stays stable while a response waits
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/tlul_slave_responder.sv
// TL-UL slave responder: accepts one A-channel request at a time, performs a
// Get or Put against a local word-addressed memory and returns the D-channel
// response RESP_LATENCY cycles after accept.
// Ports:
//   clk_24 - sole clock
//   reset  - synchronous, active-high reset
//   bus    - TL-UL A/D channels (slave modport)
// Build option:
//   TLUL_SLV_ADDR_CHECK_EN - when defined, addresses outside
//   [BASE_ADDR, BASE_ADDR + 4*MEM_DEPTH) get an error response; otherwise the
//   word index wraps modulo MEM_DEPTH (MEM_DEPTH is expected to be a power of 2).
module tlul_slave_responder
    import tlul_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned           SIZE_WIDTH   = 3,
    parameter int unsigned           SRC_WIDTH    = 2,
    parameter int unsigned           SINK_WIDTH   = 1,
    parameter int unsigned           OPCODE_WIDTH = 3,
    parameter int unsigned           PARAM_WIDTH  = 3,
    parameter int unsigned           MEM_DEPTH    = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned           RESP_LATENCY = 1
) (
    input logic                   clk_24,
    input logic                   reset,
    tlul_slave_responder_if.slave bus
);

    localparam int unsigned IdxWidth = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // WAIT covers RESP_LATENCY-1 cycles, counted 0 .. WaitLast
    localparam int unsigned WaitLast = (RESP_LATENCY >= 2) ? RESP_LATENCY - 2 : 0;
    localparam int unsigned CntWidth = (RESP_LATENCY > 2) ? $clog2(RESP_LATENCY - 1) : 1;

    tl_state_e state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    logic a_ready;
    logic accept;

    // Request decode
    logic op_get;
    logic op_put;
    logic size_bad;
    logic align_bad;
    logic range_bad;
    logic req_err;

    // Memory port
    logic                  mem_re;
    logic                  mem_we;
    logic [IdxWidth-1:0]   mem_idx;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Response register
    logic [OPCODE_WIDTH-1:0] d_opcode_q;
    logic [SIZE_WIDTH-1:0]   d_size_q;
    logic [SRC_WIDTH-1:0]    d_source_q;
    logic                    d_error_q;
    logic                    rd_data_q;

    // Held low during reset so nothing can be accepted while the block is reset
    assign a_ready = (state_q == StIdle) && !reset;
    assign accept  = bus.a_valid && a_ready;

    always_comb begin
        op_get    = bus.a_opcode == OPCODE_WIDTH'(Get);
        op_put    = (bus.a_opcode == OPCODE_WIDTH'(PutFullData)) ||
                    (bus.a_opcode == OPCODE_WIDTH'(PutPartialData));
        size_bad  = bus.a_size > SIZE_WIDTH'(2);
        align_bad = !size_bad && tl_misaligned(bus.a_address[1:0], bus.a_size[1:0]);
`ifdef TLUL_SLV_ADDR_CHECK_EN
        range_bad = ({1'b0, bus.a_address} <  {1'b0, BASE_ADDR}) ||
                    ({1'b0, bus.a_address} >= ({1'b0, BASE_ADDR} +
                                               (ADDR_WIDTH + 1)'(4 * MEM_DEPTH)));
`else
        range_bad = 1'b0;
`endif
        req_err   = !(op_get || op_put) || size_bad || align_bad || range_bad;
    end

    // Low index bits of the word offset; out-of-window addresses wrap
    assign mem_idx = IdxWidth'((bus.a_address - BASE_ADDR) >> 2);
    assign mem_we  = accept && op_put && !req_err;
    assign mem_re  = accept && op_get && !req_err;

    tlul_slave_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .MASK_WIDTH (MASK_WIDTH),
        .IDX_WIDTH  (IdxWidth)
    ) u_mem (
        .clk   (clk_24),
        .re    (mem_re),
        .we    (mem_we),
        .idx   (mem_idx),
        .wdata (bus.a_data),
        .wmask (bus.a_mask),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = (RESP_LATENCY <= 1) ? StResp : StWait;
                end
            end
            StWait: begin
                if (cnt_q == CntWidth'(WaitLast)) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (bus.d_ready) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_24) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_error_q  <= 1'b0;
            rd_data_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                // Get always answers with data, even on error (data forced to 0)
                d_opcode_q <= op_get ? OPCODE_WIDTH'(AccessAckData) : OPCODE_WIDTH'(AccessAck);
                d_size_q   <= bus.a_size;
                d_source_q <= bus.a_source;
                d_error_q  <= req_err;
                rd_data_q  <= op_get && !req_err;
            end
        end
    end

    assign bus.a_ready  = a_ready;
    assign bus.d_valid  = (state_q == StResp);
    assign bus.d_opcode = d_opcode_q;
    assign bus.d_param  = '0;
    assign bus.d_size   = d_size_q;
    assign bus.d_source = d_source_q;
    assign bus.d_sink   = '0;
    assign bus.d_error  = d_error_q;
    assign bus.d_data   = rd_data_q ? mem_rdata : '0;

endmodule

// File: tb/tb_tlul_slave_responder.sv
// Randomised self-checking bench for tlul_slave_responder. A latency-1 DUT is
// checked against a word-array memory model computed from the TL-UL rules; a
// latency-3 DUT checks response timing and reset during a pending request.
module tb_tlul_slave_responder;

    logic clk_24 = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_24 = ~clk_24;

    tlul_slave_responder_if bus ();
    tlul_slave_responder_if bus3 ();

    tlul_slave_responder dut (
        .clk_24 (clk_24),
        .reset  (reset),
        .bus    (bus.slave)
    );

    tlul_slave_responder #(
        .RESP_LATENCY (3)
    ) dut3 (
        .clk_24 (clk_24),
        .reset  (reset),
        .bus    (bus3.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mem_model [256];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference behaviour of one request; updates the model memory on a good Put.
    task automatic model_access(input logic [2:0] op, input logic [31:0] addr,
                                input logic [2:0] size, input logic [3:0] mask,
                                input logic [31:0] data, output logic [2:0] exp_op,
                                output logic exp_err, output logic [31:0] exp_data);
        int unsigned idx;
        exp_err = 1'b0;
        if (op != 3'd0 && op != 3'd1 && op != 3'd4) exp_err = 1'b1;
        if (size > 3'd2) exp_err = 1'b1;
        else if ((addr % (32'd1 << size)) != 0) exp_err = 1'b1;
`ifdef TLUL_SLV_ADDR_CHECK_EN
        if (addr < 32'h1000 || addr >= 32'h1000 + 32'd1024) exp_err = 1'b1;
`endif
        idx = ((addr - 32'h1000) / 4) % 256;
        if (op == 3'd4) begin
            exp_op   = 3'd1;
            exp_data = exp_err ? 32'h0 : mem_model[idx];
        end else begin
            exp_op   = 3'd0;
            exp_data = 32'h0;
            if (!exp_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask[b]) mem_model[idx][b*8 +: 8] = data[b*8 +: 8];
                end
            end
        end
    endtask

    // One full request/response on the latency-1 DUT; d_ready held low for 'hold' cycles.
    task automatic tl_txn(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] size,
                          input logic [3:0] mask, input logic [31:0] data, input logic [1:0] src,
                          input int hold);
        logic [2:0]  exp_op;
        logic        exp_err;
        logic [31:0] exp_data;
        int          waited;
        model_access(op, addr, size, mask, data, exp_op, exp_err, exp_data);
        @(negedge clk_24);
        bus.a_valid   = 1'b1;
        bus.a_opcode  = op;
        bus.a_param   = 3'($urandom);
        bus.a_size    = size;
        bus.a_source  = src;
        bus.a_address = addr;
        bus.a_mask    = mask;
        bus.a_data    = data;
        waited = 0;
        while (bus.a_ready !== 1'b1 && waited < 20) begin
            @(negedge clk_24);
            waited++;
        end
        check_eq("a_ready_idle", 32'(bus.a_ready), 32'd1);
        if (bus.a_ready !== 1'b1) begin
            bus.a_valid = 1'b0;
            return;
        end
        @(posedge clk_24);
        @(negedge clk_24);
        bus.a_valid = 1'b0;
        bus.d_ready = (hold == 0);
        check_eq("a_ready_busy", 32'(bus.a_ready), 32'd0);
        waited = 1;
        while (bus.d_valid !== 1'b1 && waited < 10) begin
            @(negedge clk_24);
            waited++;
        end
        check_eq("d_latency", waited, 32'd1);
        check_eq("d_opcode", 32'(bus.d_opcode), 32'(exp_op));
        check_eq("d_error", 32'(bus.d_error), 32'(exp_err));
        check_eq("d_data", bus.d_data, exp_data);
        check_eq("d_size", 32'(bus.d_size), 32'(size));
        check_eq("d_source", 32'(bus.d_source), 32'(src));
        check_eq("d_param_sink", {28'h0, bus.d_param, bus.d_sink}, 32'h0);
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk_24);
            check_eq("hold_d_valid", 32'(bus.d_valid), 32'd1);
            check_eq("hold_d_data", bus.d_data, exp_data);
            check_eq("hold_a_ready", 32'(bus.a_ready), 32'd0);
        end
        bus.d_ready = 1'b1;
        @(negedge clk_24);
        check_eq("post_d_valid", 32'(bus.d_valid), 32'd0);
        check_eq("post_a_ready", 32'(bus.a_ready), 32'd1);
    endtask

    // One request on the latency-3 DUT, optionally reset one cycle after accept.
    task automatic l3_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input bit mid_reset, input logic [31:0] exp_data);
        @(negedge clk_24);
        bus3.a_valid   = 1'b1;
        bus3.a_opcode  = op;
        bus3.a_param   = 3'd0;
        bus3.a_size    = 3'd2;
        bus3.a_source  = 2'd2;
        bus3.a_address = addr;
        bus3.a_mask    = 4'hF;
        bus3.a_data    = data;
        check_eq("l3_a_ready", 32'(bus3.a_ready), 32'd1);
        @(posedge clk_24);
        @(negedge clk_24);
        bus3.a_valid = 1'b0;
        if (mid_reset) begin
            reset = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk_24);
                check_eq("l3_rst_d_valid", 32'(bus3.d_valid), 32'd0);
                check_eq("l3_rst_a_ready", 32'(bus3.a_ready), 32'd0);
            end
            reset = 1'b0;
            @(negedge clk_24);
            check_eq("l3_rel_a_ready", 32'(bus3.a_ready), 32'd1);
            check_eq("l3_rel_a_ready1", 32'(bus.a_ready), 32'd1);
            check_eq("l3_rel_d_valid", 32'(bus3.d_valid), 32'd0);
        end else begin
            for (int c = 1; c <= 3; c++) begin
                check_eq("l3_d_valid_cyc", 32'(bus3.d_valid), (c == 3) ? 32'd1 : 32'd0);
                if (c < 3) @(negedge clk_24);
            end
            check_eq("l3_d_data", bus3.d_data, exp_data);
            check_eq("l3_d_opcode", 32'(bus3.d_opcode), (op == 3'd4) ? 32'd1 : 32'd0);
            check_eq("l3_d_error", 32'(bus3.d_error), 32'd0);
            @(negedge clk_24);
            check_eq("l3_post_d_valid", 32'(bus3.d_valid), 32'd0);
            check_eq("l3_post_a_ready", 32'(bus3.a_ready), 32'd1);
        end
    endtask

    initial begin
        logic [2:0]  op;
        logic [2:0]  size;
        logic [31:0] addr;
        int          r;
        bus.a_valid = 1'b0; bus.a_opcode = '0; bus.a_param = '0; bus.a_size = '0;
        bus.a_source = '0; bus.a_address = '0; bus.a_mask = '0; bus.a_data = '0;
        bus.d_ready = 1'b1;
        bus3.a_valid = 1'b0; bus3.a_opcode = '0; bus3.a_param = '0; bus3.a_size = '0;
        bus3.a_source = '0; bus3.a_address = '0; bus3.a_mask = '0; bus3.a_data = '0;
        bus3.d_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk_24);
        check_eq("rst_a_ready", 32'(bus.a_ready), 32'd0);
        check_eq("rst_d_valid", 32'(bus.d_valid), 32'd0);
        check_eq("rst_d_fields", {bus.d_opcode, bus.d_param, bus.d_size, bus.d_source,
                                  bus.d_sink, bus.d_error}, 32'h0);
        check_eq("rst_d_data", bus.d_data, 32'h0);
        check_eq("rst3_d_valid", 32'(bus3.d_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk_24);
        check_eq("rel_a_ready", 32'(bus.a_ready), 32'd1);
        check_eq("rel3_a_ready", 32'(bus3.a_ready), 32'd1);

        // Latency-3 timing and reset mid-transaction
        l3_txn(3'd0, 32'h1010, 32'hCAFE_F00D, 1'b0, 32'h0);
        l3_txn(3'd4, 32'h1010, 32'h0, 1'b0, 32'hCAFE_F00D);
        l3_txn(3'd0, 32'h1014, 32'h1234_5678, 1'b1, 32'h0);
        l3_txn(3'd4, 32'h1014, 32'h0, 1'b1, 32'h0);
        l3_txn(3'd4, 32'h1014, 32'h0, 1'b0, 32'h1234_5678);

        // Fill the latency-1 memory
        for (int i = 0; i < 256; i++) begin
            tl_txn(3'd0, 32'h1000 + 32'(i) * 4, 3'd2, 4'hF, $urandom, 2'(i), 0);
        end

        // Directed cases
        tl_txn(3'd0, 32'h1000, 3'd2, 4'hF, 32'hDEAD_BEEF, 2'd1, 0);
        tl_txn(3'd4, 32'h1000, 3'd2, 4'h0, 32'h0, 2'd1, 0);
        tl_txn(3'd0, 32'h1004, 3'd2, 4'hF, 32'hFFFF_FFFF, 2'd0, 0);
        tl_txn(3'd1, 32'h1004, 3'd2, 4'b0101, 32'h1122_3344, 2'd3, 0);
        tl_txn(3'd4, 32'h1004, 3'd2, 4'h0, 32'h0, 2'd2, 0);
        tl_txn(3'd4, 32'h1004, 3'd2, 4'h0, 32'h0, 2'd2, 5);
        tl_txn(3'd4, 32'h1002, 3'd2, 4'h0, 32'h0, 2'd0, 0);
        tl_txn(3'd3, 32'h1000, 3'd2, 4'hF, 32'h5555_AAAA, 2'd0, 0);
        tl_txn(3'd0, 32'h1002, 3'd2, 4'hF, 32'h5555_AAAA, 2'd0, 0);
        tl_txn(3'd0, 32'h1000, 3'd3, 4'hF, 32'h5555_AAAA, 2'd0, 0);
        tl_txn(3'd4, 32'h1000, 3'd2, 4'h0, 32'h0, 2'd0, 0);
        tl_txn(3'd4, 32'h2000, 3'd2, 4'h0, 32'h0, 2'd1, 0);
        tl_txn(3'd4, 32'h0FFC, 3'd2, 4'h0, 32'h0, 2'd1, 0);
        tl_txn(3'd4, 32'h13FC, 3'd2, 4'h0, 32'h0, 2'd1, 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      op = 3'd4;
            else if (r < 6) op = 3'd0;
            else if (r < 8) op = 3'd1;
            else            op = 3'($urandom);
            size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) :
                                                 3'($urandom_range(0, 2));
            addr = 32'h1000 + 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0 && size <= 3'd2) addr = addr & ~((32'd1 << size) - 1);
            if ($urandom_range(0, 15) == 0) addr = $urandom;
            tl_txn(op, addr, size, 4'($urandom), $urandom, 2'($urandom), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
